// File: rtl/sub_pkg.sv
// Shared types and constants for the serial ripple subtractor.
package sub_pkg;

    localparam int unsigned SUB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

    // Bit-counter width able to index 0..width-1 (at least one bit).
    function automatic int unsigned sub_cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow equations for a single bit.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per cycle, LSB first.
// Optional Overflow output enabled by macro SERIAL_SUB_OVERFLOW_EN.
module serial_ripple_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Ready,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow_Out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int unsigned      CNT_W    = sub_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             msb_bin_q, msb_bin_d;
    logic             ovf_q, ovf_d;
`endif

    logic fs_d;
    logic fs_bout;

    // Single shared bit slice, fed by the operand LSBs and the running borrow.
    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        diff_d    = diff_q;
        bout_d    = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        msb_bin_d = msb_bin_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_sh_d    = A;
                    b_sh_d    = B;
                    borrow_d  = Bin;
                    diff_sh_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                diff_sh_d = {fs_d, diff_sh_q[WIDTH-1:1]};
                borrow_d  = fs_bout;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // Borrow entering the MSB, needed for signed overflow.
                    msb_bin_d = borrow_q;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                diff_d  = diff_sh_q;
                bout_d  = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
                ovf_d   = msb_bin_q ^ borrow_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SHIFT);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            msb_bin_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            msb_bin_q <= msb_bin_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign Ready      = ready_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Diff       = diff_q;
    assign Borrow_Out = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign Overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor (WIDTH=4).
// Define SERIAL_SUB_OVERFLOW_EN to also check the Overflow output.
module tb_serial_ripple_subtractor;

    localparam int unsigned W = 4;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         Ready;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Diff;
    logic         Borrow_Out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         Overflow;
`endif

    int n_vec;
    int n_err;
    int excl_viol;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .A          (A),
        .B          (B),
        .Bin        (Bin),
        .Ready      (Ready),
        .Busy       (Busy),
        .Done       (Done),
        .Diff       (Diff),
        .Borrow_Out (Borrow_Out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .Overflow   (Overflow)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Ready and Busy must never be high together.
    always @(negedge Clk) begin
        if (Ready && Busy) excl_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation: accept, scramble inputs, wait for Done, check result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic eb,
                          input logic eov);
        int           lat;
        int           hold_err;
        logic [W-1:0] prev;
        prev     = Diff;
        hold_err = 0;
        @(negedge Clk);
        A = a; B = b; Bin = bin; Start = 1'b1;
        check({tag, "_ready"}, 32'(Ready), 32'd1);
        @(posedge Clk); #1;
        Start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        lat = 0;
        while (!Done && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
            if (!Done && Diff !== prev) hold_err++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_hold"}, 32'(hold_err), 32'd0);
        check({tag, "_diff"}, 32'(Diff), 32'(ed));
        check({tag, "_bout"}, 32'(Borrow_Out), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(Overflow), 32'(eov));
`else
        if (eov === 1'bx) $display("note: unknown overflow expectation for %s", tag);
`endif
    endtask

    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vbin [3];
    logic [W-1:0] vd [3];
    logic         vbo [3];
    logic         vov [3];

    initial begin
        int cyc;
        int dcnt;
        int k;
        int dcyc [3];
        logic [W-1:0] first_diff;

        n_vec = 0; n_err = 0; excl_viol = 0;
        Reset_n = 1'b0; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(Borrow_Out), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Basic vectors.
        run_op("f_minus_0", 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
        run_op("0_minus_1", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
        run_op("5_minus_a_b", 4'b0101, 4'b1010, 1'b1, 4'b1010, 1'b1, 1'b1);
        run_op("8_minus_1", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
        run_op("3_minus_1", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);

        // Start re-pulsed two cycles after acceptance is ignored.
        @(negedge Clk);
        A = 4'b0110; B = 4'b0001; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        A = 4'b1100; B = 4'b0111; Bin = 1'b1; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        dcnt = 0; cyc = 2; first_diff = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk); #1;
            cyc++;
            if (Done) begin
                dcnt++;
                if (dcnt == 1) begin
                    first_diff = Diff;
                    check("restart_lat", 32'(cyc), 32'd5);
                end
            end
        end
        check("restart_done_cnt", 32'(dcnt), 32'd1);
        check("restart_diff", 32'(first_diff), 32'h5);

        // Reset in the second SHIFT cycle aborts the operation.
        @(negedge Clk);
        A = 4'b1110; B = 4'b0011; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(posedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        check("abort_ready", 32'(Ready), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_bout", 32'(Borrow_Out), 32'd0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            if (Done) dcnt++;
            if (i == 1) Reset_n = 1'b1;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);
        run_op("after_abort", 4'b1110, 4'b0011, 1'b0, 4'b1011, 1'b0, 1'b0);

        // Start held high: three back-to-back operations.
        va[0] = 4'b1001; vb[0] = 4'b0011; vbin[0] = 1'b0; vd[0] = 4'b0110; vbo[0] = 1'b0; vov[0] = 1'b1;
        va[1] = 4'b0010; vb[1] = 4'b0111; vbin[1] = 1'b0; vd[1] = 4'b1011; vbo[1] = 1'b1; vov[1] = 1'b0;
        va[2] = 4'b1111; vb[2] = 4'b1111; vbin[2] = 1'b1; vd[2] = 4'b1111; vbo[2] = 1'b1; vov[2] = 1'b0;
        @(negedge Clk);
        A = va[0]; B = vb[0]; Bin = vbin[0]; Start = 1'b1;
        @(posedge Clk); #1;
        cyc = 0; k = 0;
        dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
        while (k < 3 && cyc < 40) begin
            @(posedge Clk); #1;
            cyc++;
            if (Done) begin
                dcyc[k] = cyc;
                check($sformatf("b2b_diff%0d", k), 32'(Diff), 32'(vd[k]));
                check($sformatf("b2b_bout%0d", k), 32'(Borrow_Out), 32'(vbo[k]));
`ifdef SERIAL_SUB_OVERFLOW_EN
                check($sformatf("b2b_ovf%0d", k), 32'(Overflow), 32'(vov[k]));
`endif
                k++;
                if (k < 3) begin
                    A = va[k]; B = vb[k]; Bin = vbin[k];
                end else begin
                    Start = 1'b0;
                end
            end
        end
        Start = 1'b0;
        check("b2b_count", 32'(k), 32'd3);
        check("b2b_first", 32'(dcyc[0]), 32'd5);
        check("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd6);
        check("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd6);

        repeat (3) @(posedge Clk);
        #1;
        check("ready_busy_excl", 32'(excl_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_ripple_subtractor.md
SERIAL_RIPPLE_SUBTRACTOR -- requirements
Module: serial_ripple_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port A, input, WIDTH bits: minuend, sampled on acceptance.
REQ-006 The block SHALL have port B, input, WIDTH bits: subtrahend, sampled on acceptance.
REQ-007 The block SHALL have port Bin, input, 1 bit: borrow-in, sampled on acceptance.
REQ-008 The block SHALL have port Ready, output, 1 bit: idle and able to accept Start.
REQ-009 The block SHALL have port Busy, output, 1 bit: a subtraction is in progress.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 The block SHALL have port Diff, output, WIDTH bits: result A - B - Bin modulo 2^WIDTH.
REQ-012 The block SHALL have port Borrow_Out, output, 1 bit: final borrow (1 when A < B + Bin, unsigned).

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE; IDLE->SHIFT on Start while in IDLE; SHIFT->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally.
REQ-014 Start SHALL be accepted only on a rising Clk edge with Ready=1; on acceptance, A, B and Bin are captured into internal shift/borrow registers.
REQ-015 In SHIFT, each cycle SHALL process one bit, LSB first: diff_bit = a^b^borrow, borrow_next = (~a&b)|(~(a^b)&borrow); the result bit is shifted into the Diff register from the MSB side.
REQ-016 Done SHALL rise exactly WIDTH+1 cycles after the acceptance edge and stay high for one cycle.
REQ-017 Diff and Borrow_Out SHALL update in the DONE state and hold until the next Done; they SHALL not change during SHIFT.
REQ-018 Ready = (state==IDLE); Busy = (state==SHIFT); the two SHALL never both be 1.
REQ-019 Start while Busy or in DONE SHALL be ignored, with no queuing and no effect on the current operation.
REQ-020 Start held continuously SHALL start a new operation on each return to IDLE, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 Input changes on A, B and Bin after acceptance SHALL not affect the result.

Reset
REQ-022 Reset_n=0 SHALL asynchronously force state IDLE, Ready=1, Busy=0, Done=0, Diff=0, Borrow_Out=0, and clear all internal registers.
REQ-023 Reset asserted mid-operation SHALL abort it with no Done pulse; the first Start after deassertion SHALL be accepted normally.

Configuration
REQ-024 With macro SERIAL_SUB_OVERFLOW_EN defined, the block SHALL add a 1-bit output Overflow, updated with Diff, equal to 1 when A - B - Bin (two's complement) is outside the signed WIDTH-bit range, i.e. the XOR of the borrows into and out of the MSB. It SHALL reset to 0.
REQ-025 Without SERIAL_SUB_OVERFLOW_EN, the Overflow port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-026 Shared package sub_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE), the default WIDTH constant and the bit-counter width function.
REQ-027 The per-bit logic SHALL be a sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), instantiated once.

Verification (WIDTH=4)
REQ-028 A=1111, B=0000, Bin=0, Start pulse -> Done at cycle 5 after acceptance, with Diff=1111 and Borrow_Out=0.
REQ-029 A=0000, B=0001, Bin=0 -> Diff=1111 and Borrow_Out=1; A=0101, B=1010, Bin=1 -> Diff=1010 and Borrow_Out=1.
REQ-030 Start re-pulsed with different A/B two cycles after acceptance -> ignored; the first result is unchanged and exactly one Done occurs.
REQ-031 Reset_n pulled low in the 2nd SHIFT cycle -> outputs are immediately at reset values with no Done; a new Start after release gives the correct result.
REQ-032 Start held high for 3 operations -> Done pulses spaced 6 cycles apart, each with the correct Diff.
REQ-033 With SERIAL_SUB_OVERFLOW_EN defined: A=1000, B=0001, Bin=0 -> Diff=0111 and Overflow=1; A=0011, B=0001 -> Overflow=0.
